// File: rtl/chany_retime_stage.sv
// ---------------------------------------------------------------------------
// chany_retime_stage
//
// Purpose:
//   Configurable retiming stage on the vertical routing channel, sitting
//   directly upstream of the Y connection block. Each track in each direction
//   is either a zero-latency combinational bypass or a single registered
//   pipeline stage. The choice is made by one configuration bit per track.
//   Configuration bits are loaded serially on a daisy chain. A saturating bit
//   counter reports when exactly one full frame has been shifted in.
//
// Ports:
//   clk               in   1           datapath and config-shift clock
//   Reset             in   1           asynchronous, active-high
//   cfg_en            in   1           1 = shift the config chain; outputs forced to 0
//   ccff_head         in   1           serial config input
//   ccff_tail         out  1           serial config output (last chain bit)
//   cfg_done          out  1           a full frame is loaded and cfg_en is low
//   chany_bottom_in   in   CHAN_WIDTH  upward tracks in
//   chany_top_in      in   CHAN_WIDTH  downward tracks in
//   chany_top_out     out  CHAN_WIDTH  upward tracks out (to CB bottom_in)
//   chany_bottom_out  out  CHAN_WIDTH  downward tracks out (to CB top_in)
//
// Config frame layout (2*CHAN_WIDTH bits, cfg[0] is nearest ccff_head):
//   cfg[i]            mode of upward track i    (1 = registered)
//   cfg[CHAN_WIDTH+i] mode of downward track i  (1 = registered)
// ---------------------------------------------------------------------------
module chany_retime_stage #(
    parameter int CHAN_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  cfg_en,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    output logic                  cfg_done,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out
);

    localparam int FRAME = 2 * CHAN_WIDTH;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [FRAME-1:0]      cfg_q,       cfg_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  cfg_en_prev_q, cfg_en_prev_d;
    logic [CHAN_WIDTH-1:0] pipe_up_q,   pipe_up_d;
    logic [CHAN_WIDTH-1:0] pipe_dn_q,   pipe_dn_d;

    logic [CHAN_WIDTH-1:0] mode_up;
    logic [CHAN_WIDTH-1:0] mode_dn;

    // Next-state logic.
    always_comb begin
        cfg_d         = cfg_q;
        cnt_d         = cnt_q;
        cfg_en_prev_d = cfg_en;
        // Pipeline registers always sample their inputs, so switching a
        // track to registered mode never exposes stale data.
        pipe_up_d     = chany_bottom_in;
        pipe_dn_d     = chany_top_in;

        if (cfg_en) begin
            cfg_d = {cfg_q[FRAME-2:0], ccff_head};
            // A fresh enable run restarts the count at 1 (the bit being
            // shifted this cycle); within a run the count saturates so an
            // over-shift still reports a complete frame.
            if (!cfg_en_prev_q) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cfg_q         <= '0;
            cnt_q         <= '0;
            cfg_en_prev_q <= 1'b0;
            pipe_up_q     <= '0;
            pipe_dn_q     <= '0;
        end else begin
            cfg_q         <= cfg_d;
            cnt_q         <= cnt_d;
            cfg_en_prev_q <= cfg_en_prev_d;
            pipe_up_q     <= pipe_up_d;
            pipe_dn_q     <= pipe_dn_d;
        end
    end

    assign mode_up = cfg_q[CHAN_WIDTH-1:0];
    assign mode_dn = cfg_q[FRAME-1:CHAN_WIDTH];

    // Per-track mux between registered and bypass paths; the whole channel is
    // gated to 0 while the chain is shifting so half-loaded modes never glitch
    // into the connection block.
    always_comb begin
        chany_top_out    = '0;
        chany_bottom_out = '0;
        if (!cfg_en) begin
            chany_top_out    = (mode_up & pipe_up_q) | (~mode_up & chany_bottom_in);
            chany_bottom_out = (mode_dn & pipe_dn_q) | (~mode_dn & chany_top_in);
        end
    end

    assign ccff_tail = cfg_q[FRAME-1];
    assign cfg_done  = (cnt_q == CNT_MAX) && !cfg_en;

endmodule

// File: tb/tb_chany_retime_stage.sv
// ---------------------------------------------------------------------------
// tb_chany_retime_stage
//
// Self-checking bench for chany_retime_stage. A reference model keeps the
// history of shifted config bits as a queue (newest first), the length of the
// current cfg_en run, and the previous cycle's track inputs.
// ---------------------------------------------------------------------------
module tb_chany_retime_stage;

  localparam int W     = 20;
  localparam int FRAME = 2 * W;

  logic         clk;
  logic         Reset;
  logic         cfg_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic         cfg_done;
  logic [W-1:0] chany_bottom_in;
  logic [W-1:0] chany_top_in;
  logic [W-1:0] chany_top_out;
  logic [W-1:0] chany_bottom_out;

  int n_tests;
  int n_fail;

  // Reference model state.
  logic         hist[$];      // hist[k] = k-th most recently shifted bit
  int           run_len;      // consecutive cfg_en cycles, capped at FRAME
  logic         prev_en;
  logic [W-1:0] prev_up;
  logic [W-1:0] prev_dn;

  chany_retime_stage #(.CHAN_WIDTH(W)) dut (
    .clk              (clk),
    .Reset            (Reset),
    .cfg_en           (cfg_en),
    .ccff_head        (ccff_head),
    .ccff_tail        (ccff_tail),
    .cfg_done         (cfg_done),
    .chany_bottom_in  (chany_bottom_in),
    .chany_top_in     (chany_top_in),
    .chany_top_out    (chany_top_out),
    .chany_bottom_out (chany_bottom_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model
  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < FRAME; k++) hist.push_back(1'b0);
    run_len = 0;
    prev_en = 1'b0;
    prev_up = '0;
    prev_dn = '0;
  endtask

  function automatic logic [W-1:0] exp_top_out();
    logic [W-1:0] r;
    r = '0;
    if (!cfg_en)
      for (int i = 0; i < W; i++)
        r[i] = hist[i] ? prev_up[i] : chany_bottom_in[i];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_bottom_out();
    logic [W-1:0] r;
    r = '0;
    if (!cfg_en)
      for (int i = 0; i < W; i++)
        r[i] = hist[W+i] ? prev_dn[i] : chany_top_in[i];
    return r;
  endfunction

  function automatic logic exp_tail();
    return hist[FRAME-1];
  endfunction

  function automatic logic exp_done();
    return (run_len == FRAME) && !cfg_en;
  endfunction

  // Driver tasks
  task automatic drive(input logic en, input logic head,
                       input logic [W-1:0] up, input logic [W-1:0] dn);
    cfg_en          = en;
    ccff_head       = head;
    chany_bottom_in = up;
    chany_top_in    = dn;
  endtask

  task automatic drive_rand(input logic en, input logic head);
    drive(en, head, W'($urandom), W'($urandom));
  endtask

  // Advance one clock edge and update the model with what the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (Reset) begin
      model_reset();
    end else begin
      if (cfg_en) begin
        hist.push_front(ccff_head);
        void'(hist.pop_back());
        run_len = prev_en ? ((run_len < FRAME) ? run_len + 1 : FRAME) : 1;
      end
      prev_en = cfg_en;
      prev_up = chany_bottom_in;
      prev_dn = chany_top_in;
    end
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, '0, '0);
    Reset = 1'b1;
    #1;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    apply_reset();
    drive(1'b0, 1'b0, 20'hA5A5A, W'($urandom));
    #1;
    n_tests++;
    if (chany_top_out !== 20'hA5A5A) begin
      n_fail++;
      $display("FAIL reset_bypass: got %h expected %h", chany_top_out, 20'hA5A5A);
    end
    n_tests++;
    if (chany_bottom_out !== chany_top_in) begin
      n_fail++;
      $display("FAIL reset_bypass_dn: got %h expected %h", chany_bottom_out, chany_top_in);
    end
    n_tests++;
    if (ccff_tail !== 1'b0 || cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cfg: tail=%b done=%b expected 0 0", ccff_tail, cfg_done);
    end
    tick();
  endtask

  task automatic test_all_registered();
    apply_reset();
    for (int s = 1; s <= FRAME; s++) begin
      drive_rand(1'b1, 1'b1);
      #1;
      n_tests++;
      if (chany_top_out !== '0 || chany_bottom_out !== '0) begin
        n_fail++;
        $display("FAIL shift_gate: top=%h bot=%h expected 0", chany_top_out, chany_bottom_out);
      end
      tick();
      n_tests++;
      if (ccff_tail !== (s == FRAME)) begin
        n_fail++;
        $display("FAIL ones_tail shift %0d: got %b expected %b", s, ccff_tail, (s == FRAME));
      end
    end
    drive(1'b0, 1'b0, 20'h00001, '0);
    #1;
    n_tests++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_done: got %b expected 1", cfg_done);
    end
    n_tests++;
    if (chany_top_out !== exp_top_out()) begin
      n_fail++;
      $display("FAIL ones_first: got %h expected %h", chany_top_out, exp_top_out());
    end
    tick();
    drive(1'b0, 1'b0, 20'h00002, '0);
    #1;
    n_tests++;
    if (chany_top_out !== 20'h00001) begin
      n_fail++;
      $display("FAIL ones_lag1: got %h expected %h", chany_top_out, 20'h00001);
    end
    tick();
    drive_rand(1'b0, 1'b0);
    #1;
    n_tests++;
    if (chany_top_out !== 20'h00002) begin
      n_fail++;
      $display("FAIL ones_lag2: got %h expected %h", chany_top_out, 20'h00002);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      drive_rand(1'b0, 1'b0);
      #1;
      n_tests++;
      if (chany_top_out !== prev_up || chany_bottom_out !== prev_dn) begin
        n_fail++;
        $display("FAIL ones_reg: top=%h/%h bot=%h/%h", chany_top_out, prev_up,
                 chany_bottom_out, prev_dn);
      end
    end
    tick();
  endtask

  task automatic test_single_bit();
    apply_reset();
    for (int s = 0; s < FRAME; s++) begin
      drive_rand(1'b1, (s == 0));
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      drive_rand(1'b0, 1'b0);
      #1;
      n_tests++;
      if (chany_top_out !== chany_bottom_in) begin
        n_fail++;
        $display("FAIL single_up: got %h expected %h", chany_top_out, chany_bottom_in);
      end
      n_tests++;
      if (chany_bottom_out !== {prev_dn[W-1], chany_top_in[W-2:0]}) begin
        n_fail++;
        $display("FAIL single_dn: got %h expected %h", chany_bottom_out,
                 {prev_dn[W-1], chany_top_in[W-2:0]});
      end
      tick();
    end
  endtask

  task automatic test_overshift();
    apply_reset();
    for (int s = 0; s < 45; s++) begin
      drive_rand(1'b1, 1'($urandom_range(0, 1)));
      #1;
      n_tests++;
      if (cfg_done !== 1'b0) begin
        n_fail++;
        $display("FAIL over_done_during: got %b expected 0", cfg_done);
      end
      tick();
      n_tests++;
      if (ccff_tail !== exp_tail()) begin
        n_fail++;
        $display("FAIL over_tail: got %b expected %b", ccff_tail, exp_tail());
      end
    end
    for (int c = 0; c < 15; c++) begin
      drive_rand(1'b0, 1'b0);
      #1;
      n_tests++;
      if (cfg_done !== 1'b1) begin
        n_fail++;
        $display("FAIL over_done_after: got %b expected 1", cfg_done);
      end
      n_tests++;
      if (chany_top_out !== exp_top_out() || chany_bottom_out !== exp_bottom_out()) begin
        n_fail++;
        $display("FAIL over_data: top=%h/%h bot=%h/%h", chany_top_out, exp_top_out(),
                 chany_bottom_out, exp_bottom_out());
      end
      tick();
    end
  endtask

  task automatic test_undershift();
    apply_reset();
    for (int s = 0; s < 25; s++) begin
      drive_rand(1'b1, 1'($urandom_range(0, 1)));
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive_rand(1'b0, 1'b0);
      #1;
      n_tests++;
      if (cfg_done !== 1'b0) begin
        n_fail++;
        $display("FAIL under_done: got %b expected 0", cfg_done);
      end
      n_tests++;
      if (chany_top_out !== exp_top_out() || chany_bottom_out !== exp_bottom_out()) begin
        n_fail++;
        $display("FAIL under_data: top=%h/%h bot=%h/%h", chany_top_out, exp_top_out(),
                 chany_bottom_out, exp_bottom_out());
      end
      tick();
    end
    // A new run of FRAME-1 bits must not complete a frame: the count restarts.
    for (int s = 0; s < FRAME - 1; s++) begin
      drive_rand(1'b1, 1'($urandom_range(0, 1)));
      tick();
    end
    drive_rand(1'b0, 1'b0);
    #1;
    n_tests++;
    if (cfg_done !== exp_done()) begin
      n_fail++;
      $display("FAIL restart_39: got %b expected %b", cfg_done, exp_done());
    end
    tick();
    for (int s = 0; s < FRAME; s++) begin
      drive_rand(1'b1, 1'($urandom_range(0, 1)));
      tick();
    end
    drive_rand(1'b0, 1'b0);
    #1;
    n_tests++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_40: got %b expected 1", cfg_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    apply_reset();
    for (int s = 0; s < 17; s++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    drive_rand(1'b1, 1'b1);
    Reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (chany_top_out !== '0 || chany_bottom_out !== '0 || ccff_tail !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_gate: top=%h bot=%h tail=%b expected 0", chany_top_out,
               chany_bottom_out, ccff_tail);
    end
    tick();
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_rand(1'b0, 1'b0);
      #1;
      n_tests++;
      if (chany_top_out !== chany_bottom_in || chany_bottom_out !== chany_top_in ||
          cfg_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_bypass: top=%h/%h bot=%h/%h done=%b", chany_top_out,
                 chany_bottom_in, chany_bottom_out, chany_top_in, cfg_done);
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      drive_rand(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      #1;
      n_tests++;
      if (chany_top_out !== exp_top_out() || chany_bottom_out !== exp_bottom_out() ||
          ccff_tail !== exp_tail() || cfg_done !== exp_done()) begin
        n_fail++;
        $display("FAIL random cyc %0d: top=%h/%h bot=%h/%h tail=%b/%b done=%b/%b", c,
                 chany_top_out, exp_top_out(), chany_bottom_out, exp_bottom_out(),
                 ccff_tail, exp_tail(), cfg_done, exp_done());
      end
      tick();
    end
    // Long enable bursts so full frames occur under random data.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < FRAME + r; s++) begin
        drive_rand(1'b1, 1'($urandom_range(0, 1)));
        tick();
      end
      for (int c = 0; c < 10; c++) begin
        drive_rand(1'b0, 1'b0);
        #1;
        n_tests++;
        if (chany_top_out !== exp_top_out() || chany_bottom_out !== exp_bottom_out() ||
            cfg_done !== exp_done()) begin
          n_fail++;
          $display("FAIL burst %0d: top=%h/%h bot=%h/%h done=%b/%b", r, chany_top_out,
                   exp_top_out(), chany_bottom_out, exp_bottom_out(), cfg_done, exp_done());
        end
        tick();
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset   = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    model_reset();
    #2;
    test_reset();
    test_all_registered();
    test_single_bit();
    test_overshift();
    test_undershift();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
